// File: rtl/fm_arb_pkg.sv
// Shared types and default sizes for the far-memory request arbiter.
package fm_arb_pkg;

  localparam int FM_ADDR_W  = 28;
  localparam int FM_LINE_W  = 128;
  localparam int FM_TAG_W   = 8;
  localparam int FM_Q_DEPTH = 4;
  localparam int FM_MAX_RD  = 4;

  // Requesting cache; also the value stored in the read-order FIFO.
  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } t_fm_src;

  // One buffered cache request at the default widths.
  typedef struct packed {
    logic                 wr;
    logic [FM_ADDR_W-1:0] addr;
    logic [FM_LINE_W-1:0] data;
    logic [FM_TAG_W-1:0]  tag;
  } t_fm_q_entry;

  function automatic t_fm_src other_src(input t_fm_src s);
    return (s == SRC_IC) ? SRC_DC : SRC_IC;
  endfunction

endpackage

// File: rtl/fm_arb_fifo.sv
// Generic synchronous FIFO with occupancy count. A push to a full FIFO is
// accepted only when a pop happens in the same cycle.
module fm_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q gates every read, so stale contents are never observed.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fm_req_arb.sv
// Shares the far-memory port between the I-cache and D-cache miss paths:
// per-source request queues, round-robin grant, in-order read response routing.
module fm_req_arb
  import fm_arb_pkg::*;
#(
  parameter int ADDR_W  = FM_ADDR_W,
  parameter int LINE_W  = FM_LINE_W,
  parameter int TAG_W   = FM_TAG_W,
  parameter int Q_DEPTH = FM_Q_DEPTH,
  parameter int MAX_RD  = FM_MAX_RD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic              ic_req_wr,
  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic [LINE_W-1:0] ic_req_data,
  input  logic [TAG_W-1:0]  ic_req_tag,
  input  logic              dc_req_valid,
  input  logic              dc_req_wr,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_data,
  input  logic [TAG_W-1:0]  dc_req_tag,
  output logic              ic_stall,
  output logic              dc_stall,
  output logic              fm_req_valid,
  output logic              fm_req_wr,
  output logic [ADDR_W-1:0] fm_req_addr,
  output logic [LINE_W-1:0] fm_req_data,
  output logic [TAG_W-1:0]  fm_req_tag,
  input  logic              fm_req_ready,
  input  logic              fm_rsp_valid,
  input  logic [LINE_W-1:0] fm_rsp_data,
  input  logic [TAG_W-1:0]  fm_rsp_tag,
  output logic              ic_rsp_valid,
  output logic [LINE_W-1:0] ic_rsp_data,
  output logic [TAG_W-1:0]  ic_rsp_tag,
  output logic              dc_rsp_valid,
  output logic [LINE_W-1:0] dc_rsp_data,
  output logic [TAG_W-1:0]  dc_rsp_tag,
  output logic              arb_err
);

  // Same layout as t_fm_q_entry, sized by this instance's parameters.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } t_q_entry;

  localparam int E_W    = $bits(t_q_entry);
  localparam int QCNT_W = $clog2(Q_DEPTH + 1);
  localparam int OCNT_W = $clog2(MAX_RD + 1);

  t_q_entry          ic_push_e, dc_push_e, ic_head, dc_head, win_e;
  logic [QCNT_W-1:0] ic_count, dc_count;
  logic [OCNT_W-1:0] ord_count;
  logic              ic_full, ic_empty, dc_full, dc_empty, ord_full, ord_empty;
  logic              ic_push, dc_push, ic_pop, dc_pop, ic_ovf, dc_ovf;
  logic              ic_elig, dc_elig, fire, ord_push, ord_pop, spurious;
  logic [0:0]        ord_head_raw;
  t_fm_src           ord_head, win_src, rr_q, rr_d;
  logic              arb_err_q, arb_err_d;

  assign ic_push_e = '{wr: ic_req_wr, addr: ic_req_addr, data: ic_req_data, tag: ic_req_tag};
  assign dc_push_e = '{wr: dc_req_wr, addr: dc_req_addr, data: dc_req_data, tag: dc_req_tag};

  assign ic_full   = (ic_count == QCNT_W'(Q_DEPTH));
  assign dc_full   = (dc_count == QCNT_W'(Q_DEPTH));
  assign ic_empty  = (ic_count == '0);
  assign dc_empty  = (dc_count == '0);
  assign ord_full  = (ord_count == OCNT_W'(MAX_RD));
  assign ord_empty = (ord_count == '0);

  // A pulse into a full queue is lost even if that queue pops this cycle.
  assign ic_push = ic_req_valid && !ic_full;
  assign dc_push = dc_req_valid && !dc_full;
  assign ic_ovf  = ic_req_valid && ic_full;
  assign dc_ovf  = dc_req_valid && dc_full;

  // Counts are registered, so stall only moves at the clock edge. One slot
  // stays free for a miss the cache had already launched.
  assign ic_stall = (ic_count >= QCNT_W'(Q_DEPTH - 1));
  assign dc_stall = (dc_count >= QCNT_W'(Q_DEPTH - 1));

  fm_arb_fifo #(.WIDTH(E_W), .DEPTH(Q_DEPTH)) u_ic_q (
    .clk(clk), .rst(rst), .push_i(ic_push), .data_i(ic_push_e),
    .pop_i(ic_pop), .data_o(ic_head), .count_o(ic_count)
  );

  fm_arb_fifo #(.WIDTH(E_W), .DEPTH(Q_DEPTH)) u_dc_q (
    .clk(clk), .rst(rst), .push_i(dc_push), .data_i(dc_push_e),
    .pop_i(dc_pop), .data_o(dc_head), .count_o(dc_count)
  );

  // Reads wait while the order FIFO cannot record another outstanding read.
  assign ic_elig = !ic_empty && (ic_head.wr || !ord_full);
  assign dc_elig = !dc_empty && (dc_head.wr || !ord_full);

  // Round-robin pick: the eligible head at the pointer, else the other one.
  always_comb begin
    win_src = rr_q;
    if (rr_q == SRC_IC) win_src = ic_elig ? SRC_IC : SRC_DC;
    else                win_src = dc_elig ? SRC_DC : SRC_IC;
  end

  assign win_e        = (win_src == SRC_IC) ? ic_head : dc_head;
  assign fm_req_valid = ic_elig || dc_elig;
  assign fm_req_wr    = win_e.wr;
  assign fm_req_addr  = win_e.addr;
  assign fm_req_data  = win_e.data;
  assign fm_req_tag   = win_e.tag;

  assign fire   = fm_req_valid && fm_req_ready;
  assign ic_pop = fire && (win_src == SRC_IC);
  assign dc_pop = fire && (win_src == SRC_DC);

  // Accepted reads record their source; responses retire them in order.
  assign ord_push = fire && !win_e.wr;
  assign ord_pop  = fm_rsp_valid && !ord_empty;
  assign spurious = fm_rsp_valid && ord_empty;

  fm_arb_fifo #(.WIDTH(1), .DEPTH(MAX_RD)) u_ord_q (
    .clk(clk), .rst(rst), .push_i(ord_push), .data_i(win_src),
    .pop_i(ord_pop), .data_o(ord_head_raw), .count_o(ord_count)
  );

  assign ord_head     = t_fm_src'(ord_head_raw);
  assign ic_rsp_valid = ord_pop && (ord_head == SRC_IC);
  assign dc_rsp_valid = ord_pop && (ord_head == SRC_DC);
  assign ic_rsp_data  = fm_rsp_data;
  assign ic_rsp_tag   = fm_rsp_tag;
  assign dc_rsp_data  = fm_rsp_data;
  assign dc_rsp_tag   = fm_rsp_tag;

  // Pointer passes to the loser on a grant; error flag accumulates.
  always_comb begin
    rr_d      = rr_q;
    arb_err_d = arb_err_q || ic_ovf || dc_ovf || spurious;
    if (fire) rr_d = other_src(win_src);
  end

  // Round-robin pointer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= SRC_IC;
      arb_err_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;

endmodule

// File: tb/tb_fm_req_arb.sv
// Directed self-checking bench for fm_req_arb.
module tb_fm_req_arb;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_valid, ic_req_wr, dc_req_valid, dc_req_wr;
  logic [AW-1:0] ic_req_addr, dc_req_addr;
  logic [LW-1:0] ic_req_data, dc_req_data;
  logic [TW-1:0] ic_req_tag, dc_req_tag;
  logic          ic_stall, dc_stall;
  logic          fm_req_valid, fm_req_wr, fm_req_ready;
  logic [AW-1:0] fm_req_addr;
  logic [LW-1:0] fm_req_data;
  logic [TW-1:0] fm_req_tag;
  logic          fm_rsp_valid;
  logic [LW-1:0] fm_rsp_data;
  logic [TW-1:0] fm_rsp_tag;
  logic          ic_rsp_valid, dc_rsp_valid;
  logic [LW-1:0] ic_rsp_data, dc_rsp_data;
  logic [TW-1:0] ic_rsp_tag, dc_rsp_tag;
  logic          arb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fm_req_arb dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_wr(ic_req_wr), .ic_req_addr(ic_req_addr),
    .ic_req_data(ic_req_data), .ic_req_tag(ic_req_tag),
    .dc_req_valid(dc_req_valid), .dc_req_wr(dc_req_wr), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_tag(dc_req_tag),
    .ic_stall(ic_stall), .dc_stall(dc_stall),
    .fm_req_valid(fm_req_valid), .fm_req_wr(fm_req_wr), .fm_req_addr(fm_req_addr),
    .fm_req_data(fm_req_data), .fm_req_tag(fm_req_tag), .fm_req_ready(fm_req_ready),
    .fm_rsp_valid(fm_rsp_valid), .fm_rsp_data(fm_rsp_data), .fm_rsp_tag(fm_rsp_tag),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_tag(ic_rsp_tag),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_tag(dc_rsp_tag),
    .arb_err(arb_err)
  );

  function automatic logic [LW-1:0] data_of(input logic [AW-1:0] a);
    return {4{a, 4'hC}};
  endfunction

  task automatic apply_reset();
    rst          = 1'b1;
    ic_req_valid = 1'b0; ic_req_wr = 1'b0; ic_req_addr = '0; ic_req_data = '0; ic_req_tag = '0;
    dc_req_valid = 1'b0; dc_req_wr = 1'b0; dc_req_addr = '0; dc_req_data = '0; dc_req_tag = '0;
    fm_req_ready = 1'b0;
    fm_rsp_valid = 1'b0; fm_rsp_data = '0; fm_rsp_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One-cycle request pulse on either or both caches; returns 1 ns after the edge.
  task automatic pulse(input logic icv, input logic icw, input logic [AW-1:0] ica, input logic [TW-1:0] ict,
                       input logic dcv, input logic dcw, input logic [AW-1:0] dca, input logic [TW-1:0] dct);
    ic_req_valid = icv; ic_req_wr = icw; ic_req_addr = ica; ic_req_data = data_of(ica); ic_req_tag = ict;
    dc_req_valid = dcv; dc_req_wr = dcw; dc_req_addr = dca; dc_req_data = data_of(dca); dc_req_tag = dct;
    @(posedge clk);
    #1;
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({fm_req_valid, ic_stall, dc_stall, ic_rsp_valid, dc_rsp_valid, arb_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {fm_req_valid, ic_stall, dc_stall, ic_rsp_valid, dc_rsp_valid, arb_err});
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    fm_req_ready = 1'b1;
    pulse(1'b1, 1'b0, 28'h0000123, 8'h11, 1'b0, 1'b0, '0, '0);
    n_tests++;
    if ({fm_req_valid, fm_req_wr, fm_req_addr, fm_req_tag} !== {1'b1, 1'b0, 28'h0000123, 8'h11}) begin
      n_fail++;
      $display("FAIL single_req: got v=%b wr=%b a=%h t=%h expected v=1 wr=0 a=0000123 t=11",
               fm_req_valid, fm_req_wr, fm_req_addr, fm_req_tag);
    end
    n_tests++;
    if (fm_req_data !== data_of(28'h0000123)) begin
      n_fail++;
      $display("FAIL single_req_data: got %h expected %h", fm_req_data, data_of(28'h0000123));
    end
    @(posedge clk); #1;
    n_tests++;
    if (fm_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after_grant: got valid=%b expected 0", fm_req_valid);
    end
    fm_rsp_valid = 1'b1; fm_rsp_data = {16{8'hA5}}; fm_rsp_tag = 8'h11;
    #1;
    n_tests++;
    if ({ic_rsp_valid, dc_rsp_valid, ic_rsp_tag} !== {1'b1, 1'b0, 8'h11} || ic_rsp_data !== {16{8'hA5}}) begin
      n_fail++;
      $display("FAIL single_rsp: got ic=%b dc=%b tag=%h data=%h expected ic=1 dc=0 tag=11 data=a5..a5",
               ic_rsp_valid, dc_rsp_valid, ic_rsp_tag, ic_rsp_data);
    end
    @(posedge clk); #1;
    fm_rsp_valid = 1'b0;
    #1;
    n_tests++;
    if ({arb_err, ic_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_clean: got err=%b ic_rsp=%b expected 0 0", arb_err, ic_rsp_valid);
    end
  endtask

  task automatic test_fairness();
    logic [AW-1:0] exp_addr;
    apply_reset();
    for (int i = 0; i < 3; i++)
      pulse(1'b1, 1'b1, 28'h100 + AW'(i), 8'h10 + TW'(i), 1'b1, 1'b1, 28'h200 + AW'(i), 8'h20 + TW'(i));
    n_tests++;
    if ({ic_stall, dc_stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL fair_stall: got %b expected 11", {ic_stall, dc_stall});
    end
    fm_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_addr = (i % 2 == 0) ? 28'h100 + AW'(i / 2) : 28'h200 + AW'(i / 2);
      n_tests++;
      if ({fm_req_valid, fm_req_wr, fm_req_addr} !== {1'b1, 1'b1, exp_addr} || fm_req_data !== data_of(exp_addr)) begin
        n_fail++;
        $display("FAIL fair_grant%0d: got v=%b wr=%b a=%h expected v=1 wr=1 a=%h",
                 i, fm_req_valid, fm_req_wr, fm_req_addr, exp_addr);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (fm_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_drained: got valid=%b expected 0", fm_req_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [AW-1:0] ea [3] = '{28'h300, 28'h301, 28'h302};
    logic          ew [3] = '{1'b1, 1'b0, 1'b1};
    logic [TW-1:0] et [3] = '{8'h31, 8'h32, 8'h33};
    logic          es [3] = '{1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, ew[i], ea[i], et[i], 1'b0, 1'b0, '0, '0);
      n_tests++;
      if (ic_stall !== es[i]) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got %b expected %b", i, ic_stall, es[i]);
      end
    end
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if ({fm_req_valid, fm_req_addr, ic_stall, dc_stall} !== {1'b1, 28'h300, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b a=%h ics=%b dcs=%b expected v=1 a=0000300 ics=1 dcs=0",
               fm_req_valid, fm_req_addr, ic_stall, dc_stall);
    end
    fm_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({fm_req_valid, fm_req_wr, fm_req_addr, fm_req_tag} !== {1'b1, ew[i], ea[i], et[i]}) begin
        n_fail++;
        $display("FAIL bp_issue%0d: got v=%b wr=%b a=%h t=%h expected v=1 wr=%b a=%h t=%h",
                 i, fm_req_valid, fm_req_wr, fm_req_addr, fm_req_tag, ew[i], ea[i], et[i]);
      end
      @(posedge clk); #1;
      if (i == 0) begin
        n_tests++;
        if (ic_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_unstall: got %b expected 0", ic_stall);
        end
      end
    end
    n_tests++;
    if ({fm_req_valid, arb_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_done: got v=%b err=%b expected 0 0", fm_req_valid, arb_err);
    end
  endtask

  task automatic test_outstanding();
    apply_reset();
    fm_req_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      pulse(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 28'h400 + AW'(i), 8'h40 + TW'(i));
    @(posedge clk); #1;
    n_tests++;
    if (fm_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL out_four_issued: got valid=%b expected 0", fm_req_valid);
    end
    pulse(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 28'h404, 8'h44);
    n_tests++;
    if (fm_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL out_fifth_held: got valid=%b expected 0", fm_req_valid);
    end
    pulse(1'b1, 1'b1, 28'h500, 8'h50, 1'b0, 1'b0, '0, '0);
    n_tests++;
    if ({fm_req_valid, fm_req_wr, fm_req_addr} !== {1'b1, 1'b1, 28'h500}) begin
      n_fail++;
      $display("FAIL out_write_passes: got v=%b wr=%b a=%h expected v=1 wr=1 a=0000500",
               fm_req_valid, fm_req_wr, fm_req_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (fm_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL out_read_still_held: got valid=%b expected 0", fm_req_valid);
    end
    fm_rsp_valid = 1'b1; fm_rsp_data = {16{8'h3C}}; fm_rsp_tag = 8'h40;
    #1;
    n_tests++;
    if ({ic_rsp_valid, dc_rsp_valid, dc_rsp_tag, fm_req_valid} !== {1'b0, 1'b1, 8'h40, 1'b0}) begin
      n_fail++;
      $display("FAIL out_first_rsp: got ic=%b dc=%b tag=%h reqv=%b expected ic=0 dc=1 tag=40 reqv=0",
               ic_rsp_valid, dc_rsp_valid, dc_rsp_tag, fm_req_valid);
    end
    @(posedge clk); #1;
    fm_rsp_valid = 1'b0;
    n_tests++;
    if ({fm_req_valid, fm_req_wr, fm_req_addr, fm_req_tag} !== {1'b1, 1'b0, 28'h404, 8'h44}) begin
      n_fail++;
      $display("FAIL out_read_released: got v=%b wr=%b a=%h t=%h expected v=1 wr=0 a=0000404 t=44",
               fm_req_valid, fm_req_wr, fm_req_addr, fm_req_tag);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({fm_req_valid, arb_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL out_done: got v=%b err=%b expected 0 0", fm_req_valid, arb_err);
    end
  endtask

  task automatic test_mixed_routing();
    logic [TW-1:0] tags [3] = '{8'h21, 8'h32, 8'h43};
    logic          exp_ic;
    apply_reset();
    fm_req_ready = 1'b1;
    pulse(1'b1, 1'b0, 28'h600, 8'h21, 1'b0, 1'b0, '0, '0);
    pulse(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 28'h700, 8'h32);
    pulse(1'b1, 1'b0, 28'h601, 8'h43, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    n_tests++;
    if (fm_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mix_issued: got valid=%b expected 0", fm_req_valid);
    end
    for (int i = 0; i < 3; i++) begin
      exp_ic = (i != 1);
      fm_rsp_valid = 1'b1; fm_rsp_tag = tags[i]; fm_rsp_data = {16{tags[i]}};
      #1;
      n_tests++;
      if ({ic_rsp_valid, dc_rsp_valid} !== {exp_ic, !exp_ic} ||
          (exp_ic ? ic_rsp_tag : dc_rsp_tag) !== tags[i] ||
          (exp_ic ? ic_rsp_data : dc_rsp_data) !== {16{tags[i]}}) begin
        n_fail++;
        $display("FAIL mix_rsp%0d: got ic=%b dc=%b ic_tag=%h dc_tag=%h expected ic=%b dc=%b tag=%h",
                 i, ic_rsp_valid, dc_rsp_valid, ic_rsp_tag, dc_rsp_tag, exp_ic, !exp_ic, tags[i]);
      end
      @(posedge clk); #1;
    end
    fm_rsp_valid = 1'b0;
    n_tests++;
    if (arb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mix_err: got %b expected 0", arb_err);
    end
  endtask

  task automatic test_errors();
    // Overflow: fifth pulse into a four-deep queue.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b1, 28'h800 + AW'(i), 8'h80 + TW'(i), 1'b0, 1'b0, '0, '0);
      if (i == 3) begin
        n_tests++;
        if (arb_err !== 1'b0) begin
          n_fail++;
          $display("FAIL err_full_no_flag: got %b expected 0", arb_err);
        end
      end
    end
    n_tests++;
    if ({arb_err, ic_stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL err_overflow: got err=%b stall=%b expected 1 1", arb_err, ic_stall);
    end
    fm_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({fm_req_valid, fm_req_addr} !== {1'b1, 28'h800 + AW'(i)}) begin
        n_fail++;
        $display("FAIL err_kept%0d: got v=%b a=%h expected v=1 a=%h",
                 i, fm_req_valid, fm_req_addr, 28'h800 + AW'(i));
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if ({fm_req_valid, arb_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL err_dropped_sticky: got v=%b err=%b expected 0 1", fm_req_valid, arb_err);
    end
    apply_reset();
    n_tests++;
    if (arb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset_clears: got %b expected 0", arb_err);
    end
    // Spurious response with nothing outstanding.
    fm_rsp_valid = 1'b1; fm_rsp_tag = 8'h99; fm_rsp_data = '1;
    #1;
    n_tests++;
    if ({ic_rsp_valid, dc_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL err_spurious_routed: got ic=%b dc=%b expected 0 0", ic_rsp_valid, dc_rsp_valid);
    end
    @(posedge clk); #1;
    fm_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (arb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_spurious_sticky: got %b expected 1", arb_err);
    end
    // Outstanding read discarded by reset; its late response is spurious.
    apply_reset();
    fm_req_ready = 1'b1;
    pulse(1'b1, 1'b0, 28'h900, 8'h90, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    apply_reset();
    fm_rsp_valid = 1'b1; fm_rsp_tag = 8'h90;
    #1;
    n_tests++;
    if ({ic_rsp_valid, dc_rsp_valid, arb_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL err_mid_reset_rsp: got ic=%b dc=%b err=%b expected 0 0 0",
               ic_rsp_valid, dc_rsp_valid, arb_err);
    end
    @(posedge clk); #1;
    fm_rsp_valid = 1'b0;
    n_tests++;
    if (arb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_mid_reset_flag: got %b expected 1", arb_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_back_pressure();
    test_outstanding();
    test_mixed_routing();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
